// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 responder.
// Imported by the responder top and its TX FIFO.
package spi_pkg;

    typedef logic [7:0] spi_byte_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam spi_byte_t IDLE_BYTE_DEF = 8'hFF;

endpackage

// File: rtl/spi_tx_fifo.sv
// Small TX byte FIFO; pointers carry an extra wrap bit for full/empty.
// Head is shown combinationally so a pop can load it the same cycle.
module spi_tx_fifo
    import spi_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  spi_byte_t wr_data,
    input  logic      pop,
    output spi_byte_t rd_data,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic        do_push;
    logic        do_pop;
    spi_byte_t   mem [DEPTH];

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) &&
                     (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)
                rptr <= rptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 target: oversampled SCLK/MOSI/CS_N, RX holding register,
// MSB-first TX from a FIFO with IDLE_BYTE fill on underrun.
module spi_responder
    import spi_pkg::*;
#(
    parameter int        TX_FIFO_DEPTH = 4,
    parameter int        SYNC_STAGES   = 2,
    parameter spi_byte_t IDLE_BYTE     = IDLE_BYTE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       IN_SPI_clk,
    input  logic       IN_SPI_mosi,
    input  logic       IN_SPI_cs_n,
    output logic       OUT_SPI_miso,
    output logic       OUT_SPI_misoOe,
    input  logic [7:0] IN_txData,
    input  logic       IN_txValid,
    output logic       OUT_txReady,
    output logic [7:0] OUT_rxData,
    output logic       OUT_rxValid,
    input  logic       IN_rxReady,
    output logic       OUT_rxOverrun,
    output logic       OUT_txUnderrun,
    input  logic       IN_clrErr,
    output logic       OUT_busy
);

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic sclk_s, mosi_s, cs_s;
    logic sclk_q, cs_q;
    logic rise, fall, select, deselect;

    logic [2:0] bit_cnt, bit_cnt_n;
    spi_byte_t  tx_shift, tx_shift_n;
    logic [6:0] rx_shift, rx_shift_n;
    logic       oe, oe_n;
    logic       load, byte_done;
    logic       und_set, ovr_set;
    spi_byte_t  rx_byte;

    spi_byte_t fifo_head;
    logic      fifo_full, fifo_empty;

    spi_byte_t rx_data;
    logic      rx_valid;
    logic      rx_overrun;
    logic      tx_underrun;

    spi_tx_fifo #(
        .DEPTH(TX_FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (IN_txValid),
        .wr_data(IN_txData),
        .pop    (load),
        .rd_data(fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], IN_SPI_clk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], IN_SPI_mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], IN_SPI_cs_n};
            sclk_q    <= sclk_s;
            cs_q      <= cs_s;
        end
    end

    assign sclk_s   = sclk_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign rise     = sclk_s && !sclk_q;
    assign fall     = !sclk_s && sclk_q;
    assign select   = cs_q && !cs_s;
    assign deselect = !cs_q && cs_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        tx_shift_n = tx_shift;
        rx_shift_n = rx_shift;
        oe_n       = oe;
        load       = 1'b0;
        byte_done  = 1'b0;
        unique case (state)
            IDLE: begin
                if (select) begin
                    state_n   = ACTIVE;
                    bit_cnt_n = '0;
                    oe_n      = 1'b1;
                    load      = 1'b1;
                end
            end
            ACTIVE: begin
                // Deselect wins over any edge seen in the same cycle
                if (deselect) begin
                    state_n    = IDLE;
                    oe_n       = 1'b0;
                    tx_shift_n = '0;
                    bit_cnt_n  = '0;
                end else if (rise) begin
                    rx_shift_n = {rx_shift[5:0], mosi_s};
                    bit_cnt_n  = bit_cnt + 3'd1;
                    byte_done  = (bit_cnt == 3'd7);
                end else if (fall) begin
                    if (bit_cnt != 3'd0)
                        tx_shift_n = {tx_shift[6:0], 1'b0};
                    else
                        load = 1'b1;
                end
            end
            default: ;
        endcase
        if (load)
            tx_shift_n = fifo_empty ? IDLE_BYTE : fifo_head;
    end

    assign und_set = load && fifo_empty;
    assign rx_byte = {rx_shift, mosi_s};
    assign ovr_set = byte_done && rx_valid && !IN_rxReady;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt     <= '0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            oe          <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            bit_cnt     <= bit_cnt_n;
            tx_shift    <= tx_shift_n;
            rx_shift    <= rx_shift_n;
            oe          <= oe_n;
            rx_overrun  <= ovr_set || (rx_overrun && !IN_clrErr);
            tx_underrun <= und_set || (tx_underrun && !IN_clrErr);
            if (byte_done && (!rx_valid || IN_rxReady)) begin
                rx_data  <= rx_byte;
                rx_valid <= 1'b1;
            end else if (rx_valid && IN_rxReady) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign OUT_SPI_miso   = tx_shift[7];
    assign OUT_SPI_misoOe = oe;
    assign OUT_txReady    = !fifo_full;
    assign OUT_rxData     = rx_data;
    assign OUT_rxValid    = rx_valid;
    assign OUT_rxOverrun  = rx_overrun;
    assign OUT_txUnderrun = tx_underrun;
    assign OUT_busy       = (state == ACTIVE);

endmodule

// File: tb/tb_spi_responder.sv
// Self-checking bench for spi_responder: directed table, corner
// sequences, and randomized transfers against a byte-level model.
module tb_spi_responder;

    localparam int HALF  = 6;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       cs_n = 1'b1;
    logic       miso;
    logic       miso_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       rx_ovr;
    logic       tx_und;
    logic       clr_err = 1'b0;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_q[$];
    logic [7:0] mq[$];

    spi_responder dut (
        .clk           (clk),
        .rst           (rst),
        .IN_SPI_clk    (sclk),
        .IN_SPI_mosi   (mosi),
        .IN_SPI_cs_n   (cs_n),
        .OUT_SPI_miso  (miso),
        .OUT_SPI_misoOe(miso_oe),
        .IN_txData     (tx_data),
        .IN_txValid    (tx_valid),
        .OUT_txReady   (tx_ready),
        .OUT_rxData    (rx_data),
        .OUT_rxValid   (rx_valid),
        .IN_rxReady    (rx_ready),
        .OUT_rxOverrun (rx_ovr),
        .OUT_txUnderrun(tx_und),
        .IN_clrErr     (clr_err),
        .OUT_busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (rx_valid && rx_ready)
            rx_q.push_back(rx_data);

    typedef struct {
        int          npush;
        logic [31:0] push_w;
        int          nbits;
        logic [31:0] mosi_w;
        bit          rdy;
        logic [31:0] e_miso;
        logic [7:0]  e_rx;
        bit          e_rxv;
        bit          e_ovr;
        bit          e_und;
    } vec_t;

    vec_t tbl[4];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
    endtask

    task automatic cleanup();
        rx_ready = 1'b1;
        clr_err  = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        clr_err  = 1'b0;
        tick(1);
        rx_q.delete();
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        tick(HALF);
    endtask

    // Deselect together with the final falling edge, as the master does
    task automatic cs_high();
        cs_n = 1'b1;
        sclk = 1'b0;
        tick(HALF);
    endtask

    task automatic xbits(input int nbits, input logic [31:0] mw,
                         output logic [31:0] sw);
        sw = '0;
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b0;
            mosi = mw[nbits-1-i];
            tick(HALF);
            sw   = {sw[30:0], miso};
            sclk = 1'b1;
            tick(HALF);
        end
    endtask

    task automatic xfer(input int nbits, input logic [31:0] mw,
                        output logic [31:0] sw, output logic act);
        cs_low();
        act = busy && miso_oe;
        xbits(nbits, mw, sw);
        cs_high();
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        logic [31:0] sw;
        logic        act;
        logic [31:0] packed_rx;
        cleanup();
        for (int k = 0; k < v.npush; k++)
            push(v.push_w[31-8*k -: 8]);
        rx_ready = v.rdy;
        xfer(v.nbits, v.mosi_w, sw, act);
        rx_ready = 1'b0;
        check({tag, " active"}, act, 1);
        check({tag, " miso"}, sw, v.e_miso);
        check({tag, " rxValid"}, rx_valid, v.e_rxv);
        check({tag, " rxData"}, rx_data, v.e_rx);
        check({tag, " overrun"}, rx_ovr, v.e_ovr);
        check({tag, " underrun"}, tx_und, v.e_und);
        check({tag, " idle outs"}, {busy, miso_oe, miso}, 3'b000);
        if (v.rdy) begin
            packed_rx = '0;
            foreach (rx_q[j])
                packed_rx = {packed_rx[23:0], rx_q[j]};
            check({tag, " rx count"}, rx_q.size(), v.nbits / 8);
            check({tag, " rx order"}, packed_rx, v.mosi_w);
            check({tag, " fifo empty"}, tx_ready, 1);
        end
    endtask

    initial begin
        logic [31:0] sw;
        logic        act;

        tbl[0] = '{1, 32'h3C000000, 8, 32'hA5, 1'b0,
                   32'h3C, 8'hA5, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{0, 32'h0, 8, 32'hC3, 1'b0,
                   32'hFF, 8'hC3, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{0, 32'h0, 16, 32'h1234, 1'b0,
                   32'hFFFF, 8'h12, 1'b1, 1'b1, 1'b1};
        tbl[3] = '{4, 32'h11223344, 32, 32'hDEADBEEF, 1'b1,
                   32'h11223344, 8'hEF, 1'b0, 1'b0, 1'b0};

        tick(2);
        check("reset outs", {miso, miso_oe, busy, rx_valid, rx_ovr, tx_und},
              6'b000000);
        check("reset rxData", rx_data, 8'h00);
        check("reset txReady", tx_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        tick(2);

        for (int i = 0; i < 4; i++)
            apply_vec(tbl[i], $sformatf("vec%0d", i));

        // Sticky underrun: clear, then set and clear in the same cycle
        cleanup();
        xfer(8, 32'h00, sw, act);
        check("und set", tx_und, 1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("und cleared", tx_und, 0);
        cs_n    = 1'b0;
        clr_err = 1'b1;
        tick(3);
        clr_err = 1'b0;
        check("und set beats clr", tx_und, 1);
        tick(1);
        check("und holds", tx_und, 1);
        tick(HALF);
        xbits(8, 32'h00, sw);
        cs_high();

        // rxReady lands exactly on the second byte's completion
        cleanup();
        cs_low();
        xbits(15, 32'h1234 >> 1, sw);
        sclk = 1'b0;
        mosi = 1'b0;
        tick(HALF);
        sclk = 1'b1;
        tick(2);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        tick(HALF - 3);
        cs_high();
        check("consume-complete rxData", rx_data, 8'h34);
        check("consume-complete rxValid", rx_valid, 1);
        check("consume-complete ovr", rx_ovr, 0);

        // Full FIFO, dropped push, partial-byte abort
        cleanup();
        push(8'h51);
        push(8'h52);
        push(8'h53);
        push(8'h54);
        check("full txReady", tx_ready, 0);
        push(8'h55);
        check("full after extra push", tx_ready, 0);
        cs_low();
        xbits(5, 32'h16, sw);
        cs_high();
        check("partial miso", sw, 32'h0A);
        check("partial rxValid", rx_valid, 0);
        xfer(8, 32'h96, sw, act);
        check("realign miso", sw, 32'h52);
        check("realign rxData", rx_data, 8'h96);
        check("realign rxValid", rx_valid, 1);
        cleanup();
        xfer(16, 32'h0, sw, act);
        check("drain miso", sw, 32'h5354);
        check("drain und", tx_und, 0);
        xfer(8, 32'h0, sw, act);
        check("extra push dropped", sw, 32'hFF);
        check("empty und", tx_und, 1);

        // Asynchronous reset in the middle of a byte
        cleanup();
        xfer(8, 32'h77, sw, act);
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        push(8'hA4);
        cs_low();
        xbits(4, 32'h9, sw);
        #2;
        rst = 1'b1;
        #1;
        check("async rst outs",
              {miso, miso_oe, busy, rx_valid, rx_ovr, tx_und}, 6'b000000);
        check("async rst rxData", rx_data, 8'h00);
        check("async rst txReady", tx_ready, 1);
        cs_n = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick(HALF);
        apply_vec(tbl[0], "post-rst");

        // Randomized transfers against a byte-queue model
        mq.delete();
        for (int it = 0; it < 24; it++) begin
            int          np;
            int          nbits;
            int          npop;
            int          nfull;
            logic [31:0] mw;
            logic [31:0] stream;
            logic [31:0] e_miso;
            logic [7:0]  e_rx;
            bit          e_und;
            logic [7:0]  d;
            cleanup();
            np = $urandom_range(0, 5);
            for (int k = 0; k < np; k++) begin
                d = 8'($urandom);
                check("rnd txReady", tx_ready, mq.size() < DEPTH);
                if (mq.size() < DEPTH)
                    mq.push_back(d);
                push(d);
            end
            case ($urandom_range(0, 3))
                0: nbits = 8;
                1: nbits = 16;
                2: nbits = 32;
                default: nbits = $urandom_range(1, 31);
            endcase
            mw     = $urandom;
            npop   = (nbits + 7) / 8;
            nfull  = nbits / 8;
            stream = '0;
            e_und  = 1'b0;
            for (int p = 0; p < npop; p++) begin
                if (mq.size() > 0) begin
                    stream = {stream[23:0], mq.pop_front()};
                end else begin
                    stream = {stream[23:0], 8'hFF};
                    e_und  = 1'b1;
                end
            end
            e_miso = stream >> (8 * npop - nbits);
            e_rx   = 8'(mw >> (nbits - 8));
            xfer(nbits, mw, sw, act);
            check("rnd miso", sw, e_miso);
            check("rnd und", tx_und, e_und);
            check("rnd rxValid", rx_valid, nfull > 0);
            if (nfull > 0)
                check("rnd rxData", rx_data, e_rx);
            check("rnd ovr", rx_ovr, nfull > 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
